// File: rtl/branch_target_buffer.sv
// Direct-mapped BTB with 2-bit counters: zero-latency lookup, training on one edge, no backpressure.
// Define BTB_STATS_EN to add the stat_updates / stat_mispredicts counters.
module branch_target_buffer #(
    parameter int IDX_BITS = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] IF_addr,
    output logic [31:0] BTB_target,
    output logic        IF_prediction,
    input  logic        MEM_update,
    input  logic [31:0] MEM_pc,
    input  logic        MEM_taken,
    input  logic [31:0] MEM_target,
    input  logic        MEM_pred
`ifdef BTB_STATS_EN
    ,
    output logic [31:0] stat_updates,
    output logic [31:0] stat_mispredicts
`endif
);

    localparam int N  = 1 << IDX_BITS;
    localparam int TW = 32 - IDX_BITS - 2;

    logic [N-1:0]    valid_q;
    logic [TW-1:0]   tag_q [N];
    logic [31:0]     tgt_q [N];
    logic [1:0]      ctr_q [N];

    logic [IDX_BITS-1:0] if_idx;
    logic [TW-1:0]       if_tag;
    logic                if_hit;

    logic [IDX_BITS-1:0] up_idx;
    logic [TW-1:0]       up_tag;
    logic                up_hit;
    logic                up_we;
    logic [1:0]          ctr_d;
    logic [31:0]         tgt_d;

    // Address bits below the word offset never select an entry.
    logic [4:0] addr_unused;
    assign addr_unused = {IF_addr[1:0], MEM_pc[1:0], MEM_target[0]};

    assign if_idx        = IF_addr[IDX_BITS+1:2];
    assign if_tag        = IF_addr[31:IDX_BITS+2];
    assign if_hit        = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
    assign IF_prediction = if_hit && ctr_q[if_idx][1];
    assign BTB_target    = if_hit ? tgt_q[if_idx] : 32'h0;

    assign up_idx = MEM_pc[IDX_BITS+1:2];
    assign up_tag = MEM_pc[31:IDX_BITS+2];
    assign up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);

    always_comb begin
        up_we = 1'b0;
        ctr_d = ctr_q[up_idx];
        tgt_d = tgt_q[up_idx];
        if (MEM_update) begin
            if (up_hit) begin
                up_we = 1'b1;
                if (MEM_taken) begin
                    ctr_d = (ctr_q[up_idx] == 2'b11) ? 2'b11 : ctr_q[up_idx] + 2'd1;
                    tgt_d = {MEM_target[31:1], 1'b0};
                end else begin
                    ctr_d = (ctr_q[up_idx] == 2'b00) ? 2'b00 : ctr_q[up_idx] - 2'd1;
                end
            end else if (MEM_taken) begin
                // Not-taken misses are never allocated, so aliases only evict on taken.
                up_we = 1'b1;
                ctr_d = 2'b10;
                tgt_d = {MEM_target[31:1], 1'b0};
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            for (int i = 0; i < N; i++) begin
                tag_q[i] <= '0;
                tgt_q[i] <= '0;
                ctr_q[i] <= 2'b01;
            end
        end else if (up_we) begin
            valid_q[up_idx] <= 1'b1;
            tag_q[up_idx]   <= up_tag;
            tgt_q[up_idx]   <= tgt_d;
            ctr_q[up_idx]   <= ctr_d;
        end
    end

`ifdef BTB_STATS_EN
    logic [31:0] stat_upd_q, stat_upd_d;
    logic [31:0] stat_mis_q, stat_mis_d;

    always_comb begin
        stat_upd_d = stat_upd_q;
        stat_mis_d = stat_mis_q;
        if (MEM_update) begin
            stat_upd_d = stat_upd_q + 32'd1;
            if (MEM_pred != MEM_taken) begin
                stat_mis_d = stat_mis_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_upd_q <= '0;
            stat_mis_q <= '0;
        end else begin
            stat_upd_q <= stat_upd_d;
            stat_mis_q <= stat_mis_d;
        end
    end

    assign stat_updates     = stat_upd_q;
    assign stat_mispredicts = stat_mis_q;
`else
    logic pred_unused;
    assign pred_unused = MEM_pred;
`endif

endmodule
